fde_datapath: RTL and testbench

Front-end and execute datapath of the 5-stage pipelined CPU. It combines three parts:
- Fetch: the PC register and the incrementer.
- Decode: field extraction, immediate generation and the register file with write-back port.
- Execute: forwarding muxes, operand select and the ALU with NZVC flags.

Pipeline registers, control unit, hazard unit and memory are external.

---
 rtl/fde_datapath_if.sv | 53 +++++
 rtl/fde_datapath.sv | 132 +++++++++++++
 tb/tb_fde_datapath.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fde_datapath_if.sv
// rtl/fde_datapath_if.sv - fetch/decode/execute signal bundle for fde_datapath
interface fde_datapath_if #(
  parameter int WIDTH            = 32,
  parameter int ADDRESSWIDTH     = 4,
  parameter int OPCODEWIDTH      = 4,
  parameter int INSTRUCTIONWIDTH = 24
);
  logic                        pc_en;
  logic                        take_branch;
  logic [WIDTH-1:0]            branch_target;
  logic [WIDTH-1:0]            pc;
  logic [WIDTH-1:0]            pc_plus1;
  logic [INSTRUCTIONWIDTH-1:0] instruction_d;
  logic                        wb_en;
  logic [ADDRESSWIDTH-1:0]     wb_addr;
  logic [WIDTH-1:0]            wb_data;
  logic [WIDTH-1:0]            reg1_data;
  logic [WIDTH-1:0]            reg2_data;
  logic [WIDTH-1:0]            imm;
  logic [ADDRESSWIDTH-1:0]     rd_addr;
  logic [ADDRESSWIDTH-1:0]     rs1_addr;
  logic [ADDRESSWIDTH-1:0]     rs2_addr;
  logic [OPCODEWIDTH-1:0]      opcode;
  logic [WIDTH-1:0]            reg1_e;
  logic [WIDTH-1:0]            reg2_e;
  logic [WIDTH-1:0]            imm_e;
  logic [WIDTH-1:0]            fwd_m;
  logic [WIDTH-1:0]            fwd_wb;
  logic [1:0]                  fwd1_sel;
  logic [1:0]                  fwd2_sel;
  logic                        src2_sel;
  logic [2:0]                  alu_ctrl;
  logic [WIDTH-1:0]            reg2_final;
  logic [WIDTH-1:0]            alu_out;
  logic                        flag_n;
  logic                        flag_z;
  logic                        flag_v;
  logic                        flag_c;

  modport master (
    output pc_en, take_branch, branch_target, instruction_d, wb_en, wb_addr, wb_data,
           reg1_e, reg2_e, imm_e, fwd_m, fwd_wb, fwd1_sel, fwd2_sel, src2_sel, alu_ctrl,
    input  pc, pc_plus1, reg1_data, reg2_data, imm, rd_addr, rs1_addr, rs2_addr, opcode,
           reg2_final, alu_out, flag_n, flag_z, flag_v, flag_c
  );

  modport slave (
    input  pc_en, take_branch, branch_target, instruction_d, wb_en, wb_addr, wb_data,
           reg1_e, reg2_e, imm_e, fwd_m, fwd_wb, fwd1_sel, fwd2_sel, src2_sel, alu_ctrl,
    output pc, pc_plus1, reg1_data, reg2_data, imm, rd_addr, rs1_addr, rs2_addr, opcode,
           reg2_final, alu_out, flag_n, flag_z, flag_v, flag_c
  );
endinterface

// File: rtl/fde_datapath.sv
// rtl/fde_datapath.sv - PC/fetch, decode + register file, forwarding and NZVC ALU
// Define ALU_SHIFT_EN to build the shifter for alu_ctrl 101/110; otherwise those codes give 0.
module fde_datapath #(
  parameter int WIDTH            = 32,
  parameter int REGNUM           = 16,
  parameter int ADDRESSWIDTH     = 4,
  parameter int OPCODEWIDTH      = 4,
  parameter int INSTRUCTIONWIDTH = 24
) (
  input  logic          clock,
  input  logic          reset,
  fde_datapath_if.slave bus
);
  localparam int OP_LSB  = INSTRUCTIONWIDTH - OPCODEWIDTH;
  localparam int RD_LSB  = OP_LSB - ADDRESSWIDTH;
  localparam int RS1_LSB = RD_LSB - ADDRESSWIDTH;
  localparam int RS2_LSB = RS1_LSB - ADDRESSWIDTH;
  localparam int MSB     = WIDTH - 1;
  localparam logic [ADDRESSWIDTH-1:0] PC_REG = ADDRESSWIDTH'(REGNUM - 1);

  logic [WIDTH-1:0]                r_pc;
  logic [WIDTH-1:0]                r_regs [REGNUM];
  logic [WIDTH-1:0]                w_pc_plus1;
  logic [INSTRUCTIONWIDTH-1:0]     w_instr;
  logic [ADDRESSWIDTH-1:0]         w_rs1;
  logic [ADDRESSWIDTH-1:0]         w_rs2;
  logic [WIDTH-1:0]                w_rd1;
  logic [WIDTH-1:0]                w_rd2;
  logic [WIDTH-1:0]                w_src_a;
  logic [WIDTH-1:0]                w_reg2_fwd;
  logic [WIDTH-1:0]                w_src_b;
  logic [WIDTH:0]                  w_sum;
  logic [WIDTH:0]                  w_diff;
  logic [WIDTH-1:0]                w_alu;
  logic                            w_c;
  logic                            w_v;

  assign w_pc_plus1 = r_pc + WIDTH'(1);

  // A branch redirect wins over a stall.
  always_ff @(posedge clock) begin
    if (!reset)                r_pc <= '0;
    else if (bus.take_branch)  r_pc <= bus.branch_target;
    else if (bus.pc_en)        r_pc <= w_pc_plus1;
  end

  assign w_instr      = bus.instruction_d;
  assign w_rs1        = w_instr[RS1_LSB +: ADDRESSWIDTH];
  assign w_rs2        = w_instr[RS2_LSB +: ADDRESSWIDTH];
  assign bus.opcode   = w_instr[OP_LSB +: OPCODEWIDTH];
  assign bus.rd_addr  = w_instr[RD_LSB +: ADDRESSWIDTH];
  assign bus.rs1_addr = w_rs1;
  assign bus.rs2_addr = w_rs2;
  assign bus.imm      = {{(WIDTH-12){w_instr[11]}}, w_instr[11:0]};

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < REGNUM; i++) r_regs[i] <= '0;
    end else if (bus.wb_en && bus.wb_addr != PC_REG) begin
      r_regs[bus.wb_addr] <= bus.wb_data;
    end
  end

  // r15 aliases the PC+1 and is never bypassed.
  always_comb begin
    if (w_rs1 == PC_REG)                            w_rd1 = w_pc_plus1;
    else if (bus.wb_en && bus.wb_addr == w_rs1)     w_rd1 = bus.wb_data;
    else                                            w_rd1 = r_regs[w_rs1];
  end

  always_comb begin
    if (w_rs2 == PC_REG)                            w_rd2 = w_pc_plus1;
    else if (bus.wb_en && bus.wb_addr == w_rs2)     w_rd2 = bus.wb_data;
    else                                            w_rd2 = r_regs[w_rs2];
  end

  always_comb begin
    case (bus.fwd1_sel)
      2'b01:   w_src_a = bus.fwd_wb;
      2'b10:   w_src_a = bus.fwd_m;
      default: w_src_a = bus.reg1_e;
    endcase
    case (bus.fwd2_sel)
      2'b01:   w_reg2_fwd = bus.fwd_wb;
      2'b10:   w_reg2_fwd = bus.fwd_m;
      default: w_reg2_fwd = bus.reg2_e;
    endcase
  end

  assign w_src_b = bus.src2_sel ? bus.imm_e : w_reg2_fwd;
  assign w_sum   = {1'b0, w_src_a} + {1'b0, w_src_b};
  assign w_diff  = {1'b0, w_src_a} - {1'b0, w_src_b};

  always_comb begin
    w_alu = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    case (bus.alu_ctrl)
      3'b000: begin
        w_alu = w_sum[MSB:0];
        w_c   = w_sum[WIDTH];
        w_v   = (w_src_a[MSB] == w_src_b[MSB]) && (w_sum[MSB] != w_src_a[MSB]);
      end
      3'b001: begin
        // Carry on subtract is the inverted borrow.
        w_alu = w_diff[MSB:0];
        w_c   = ~w_diff[WIDTH];
        w_v   = (w_src_a[MSB] != w_src_b[MSB]) && (w_diff[MSB] != w_src_a[MSB]);
      end
      3'b010: w_alu = w_src_a & w_src_b;
      3'b011: w_alu = w_src_a | w_src_b;
      3'b100: w_alu = w_src_a ^ w_src_b;
`ifdef ALU_SHIFT_EN
      3'b101: w_alu = w_src_a << w_src_b[4:0];
      3'b110: w_alu = w_src_a >> w_src_b[4:0];
`endif
      3'b111: w_alu = w_src_b;
      default: w_alu = '0;
    endcase
  end

  assign bus.pc         = r_pc;
  assign bus.pc_plus1   = w_pc_plus1;
  assign bus.reg1_data  = w_rd1;
  assign bus.reg2_data  = w_rd2;
  assign bus.reg2_final = w_reg2_fwd;
  assign bus.alu_out    = w_alu;
  assign bus.flag_n     = w_alu[MSB];
  assign bus.flag_z     = (w_alu == '0);
  assign bus.flag_v     = w_v;
  assign bus.flag_c     = w_c;
endmodule

// File: tb/tb_fde_datapath.sv
// tb/tb_fde_datapath.sv - self-checking bench for fde_datapath
module tb_fde_datapath;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  fde_datapath_if u_if ();
  fde_datapath u_dut (.clock(clock), .reset(reset), .bus(u_if.slave));

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_regs [16];
  logic [31:0] m_pc;

  typedef struct {
    logic [1:0]  f1, f2;
    logic        s2;
    logic [2:0]  ctrl;
    logic [31:0] r1, r2, im, fm, fwb;
    logic [31:0] exp_y, exp_r2f;
    logic [3:0]  exp_f;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] f1, f2, input logic s2, input logic [2:0] ctrl,
                              input logic [31:0] r1, r2, im, fm, fwb, ey,
                              input logic [3:0] ef, input logic [31:0] er2f);
    vec_t v;
    v.f1 = f1; v.f2 = f2; v.s2 = s2; v.ctrl = ctrl;
    v.r1 = r1; v.r2 = r2; v.im = im; v.fm = fm; v.fwb = fwb;
    v.exp_y = ey; v.exp_f = ef; v.exp_r2f = er2f;
    return v;
  endfunction

  function automatic logic [31:0] fwd_pick(input logic [1:0] s, input logic [31:0] base, wb, m);
    if (s == 2'd1) return wb;
    if (s == 2'd2) return m;
    return base;
  endfunction

  // Reference ALU: flags from full-precision integer arithmetic.
  function automatic void alu_model(input logic [2:0] ctrl, input logic [31:0] a, b,
                                    output logic [31:0] y, output logic [3:0] nzvc);
    longint sa, sb;
    logic c, v;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    c = 1'b0; v = 1'b0; y = '0;
    case (ctrl)
      3'd0: begin
        y = a + b;
        c = (longint'(a) + longint'(b)) > longint'(32'hFFFF_FFFF);
        v = (sa + sb) != longint'($signed(y));
      end
      3'd1: begin
        y = a - b;
        c = (a >= b);
        v = (sa - sb) != longint'($signed(y));
      end
      3'd2: y = a & b;
      3'd3: y = a | b;
      3'd4: y = a ^ b;
`ifdef ALU_SHIFT_EN
      3'd5: y = a << (b % 32);
      3'd6: y = a >> (b % 32);
`else
      3'd5: y = '0;
      3'd6: y = '0;
`endif
      default: y = b;
    endcase
    nzvc = {y[31], y == 32'd0, v, c};
  endfunction

  function automatic logic [31:0] rf_model(input logic [3:0] a, input logic we,
                                           input logic [3:0] wa, input logic [31:0] wd);
    if (a == 4'd15) return m_pc + 32'd1;
    if (we && wa == a) return wd;
    return m_regs[a];
  endfunction

  task automatic drive_exec(input vec_t v, input logic [2:0] ctrl_unused);
    u_if.fwd1_sel = v.f1; u_if.fwd2_sel = v.f2; u_if.src2_sel = v.s2; u_if.alu_ctrl = v.ctrl;
    u_if.reg1_e = v.r1; u_if.reg2_e = v.r2; u_if.imm_e = v.im;
    u_if.fwd_m = v.fm; u_if.fwd_wb = v.fwb;
    if (ctrl_unused != 3'd0) u_if.alu_ctrl = v.ctrl;
  endtask

  task automatic check_exec(input string tag, input logic [31:0] ey, input logic [3:0] ef,
                            input logic [31:0] er2f);
    chk({tag, " alu_out"}, u_if.alu_out, ey);
    chk({tag, " nzvc"}, {28'd0, u_if.flag_n, u_if.flag_z, u_if.flag_v, u_if.flag_c}, {28'd0, ef});
    chk({tag, " reg2_final"}, u_if.reg2_final, er2f);
  endtask

  initial begin
    logic [31:0] ey, a, b, r2f, exp_imm;
    logic [3:0]  ef;
    logic [23:0] ins;
    logic        pe, tbr, we;
    logic [3:0]  wa;
    logic [31:0] tgt, wd;
    int          iv;
    vec_t        rv;

    reset = 1'b0;
    u_if.pc_en = 1'b1; u_if.take_branch = 1'b0; u_if.branch_target = '0;
    u_if.instruction_d = '0; u_if.wb_en = 1'b0; u_if.wb_addr = '0; u_if.wb_data = '0;
    u_if.reg1_e = '0; u_if.reg2_e = '0; u_if.imm_e = '0; u_if.fwd_m = '0; u_if.fwd_wb = '0;
    u_if.fwd1_sel = '0; u_if.fwd2_sel = '0; u_if.src2_sel = 1'b0; u_if.alu_ctrl = '0;

    // Reset state
    @(posedge clock); #1;
    chk("reset pc", u_if.pc, 32'd0);
    chk("reset pc_plus1", u_if.pc_plus1, 32'd1);
    for (int i = 0; i < 15; i++) begin
      u_if.instruction_d = {8'h00, 4'(i), 4'(14 - i), 8'h00};
      @(negedge clock);
      chk($sformatf("reset r%0d", i), u_if.reg1_data, 32'd0);
      chk($sformatf("reset r%0d", 14 - i), u_if.reg2_data, 32'd0);
    end

    // Fetch sequencing
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("pc after 3", u_if.pc, 32'd3);
    chk("pc_plus1 after 3", u_if.pc_plus1, 32'd4);
    repeat (2) @(posedge clock);
    #1;
    chk("pc at 5", u_if.pc, 32'd5);
    u_if.pc_en = 1'b0; u_if.take_branch = 1'b1; u_if.branch_target = 32'h40;
    @(posedge clock); #1;
    chk("branch stalled", u_if.pc, 32'h40);
    u_if.take_branch = 1'b0;
    @(posedge clock); #1;
    chk("pc hold", u_if.pc, 32'h40);
    u_if.pc_en = 1'b1; u_if.take_branch = 1'b1; u_if.branch_target = 32'd7;
    @(posedge clock); #1;
    chk("branch priority", u_if.pc, 32'd7);
    u_if.pc_en = 1'b0; u_if.take_branch = 1'b0;

    // r15 is PC+1; writes and bypass ignored
    u_if.instruction_d = 24'h00F000;
    u_if.wb_en = 1'b1; u_if.wb_addr = 4'd15; u_if.wb_data = 32'hDEAD_BEEF;
    @(negedge clock);
    chk("r15 read", u_if.reg1_data, 32'd8);
    @(posedge clock); #1;
    u_if.wb_en = 1'b0;
    u_if.instruction_d = 24'h00FF00;
    @(negedge clock);
    chk("r15 after write rs1", u_if.reg1_data, 32'd8);
    chk("r15 after write rs2", u_if.reg2_data, 32'd8);

    // Write-through then storage
    @(posedge clock); #1;
    u_if.instruction_d = 24'h003000;
    u_if.wb_en = 1'b1; u_if.wb_addr = 4'd3; u_if.wb_data = 32'h1234;
    @(negedge clock);
    chk("r3 bypass", u_if.reg1_data, 32'h1234);
    @(posedge clock); #1;
    u_if.wb_en = 1'b0;
    @(negedge clock);
    chk("r3 stored", u_if.reg1_data, 32'h1234);

    // Decode fields
    u_if.instruction_d = 24'h5A3FFF;
    @(negedge clock);
    chk("opcode", 32'(u_if.opcode), 32'h5);
    chk("rd", 32'(u_if.rd_addr), 32'hA);
    chk("rs1", 32'(u_if.rs1_addr), 32'h3);
    chk("rs2", 32'(u_if.rs2_addr), 32'hF);
    chk("imm neg", u_if.imm, 32'hFFFF_FFFF);
    u_if.instruction_d = 24'h0007FF;
    @(negedge clock);
    chk("imm pos", u_if.imm, 32'h0000_07FF);

    // PC wrap
    @(posedge clock); #1;
    u_if.take_branch = 1'b1; u_if.branch_target = 32'hFFFF_FFFF;
    @(posedge clock); #1;
    u_if.take_branch = 1'b0;
    chk("pc_plus1 wrap", u_if.pc_plus1, 32'd0);
    u_if.pc_en = 1'b1;
    @(posedge clock); #1;
    chk("pc wrap", u_if.pc, 32'd0);
    u_if.pc_en = 1'b0;

    // Execute table
    vecs.push_back(mk(2'd0, 2'd0, 1'b0, 3'd0, 32'h7FFF_FFFF, 32'd1, 32'd0, 32'd0, 32'd0, 32'h8000_0000, 4'b1010, 32'd1));
    vecs.push_back(mk(2'd0, 2'd0, 1'b0, 3'd1, 32'd5, 32'd5, 32'd0, 32'd0, 32'd0, 32'd0, 4'b0101, 32'd5));
    vecs.push_back(mk(2'd2, 2'd1, 1'b0, 3'd1, 32'hAAAA, 32'hBBBB, 32'd0, 32'd9, 32'd4, 32'd5, 4'b0001, 32'd4));
    vecs.push_back(mk(2'd2, 2'd1, 1'b1, 3'd1, 32'hAAAA, 32'hBBBB, 32'd2, 32'd9, 32'd4, 32'd7, 4'b0001, 32'd4));
    vecs.push_back(mk(2'd0, 2'd0, 1'b0, 3'd2, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'd0, 32'd0, 32'd0, 32'h00F0_00F0, 4'b0000, 32'h0FF0_0FF0));
    vecs.push_back(mk(2'd0, 2'd0, 1'b0, 3'd3, 32'h8000_0000, 32'd1, 32'd0, 32'd0, 32'd0, 32'h8000_0001, 4'b1000, 32'd1));
    vecs.push_back(mk(2'd0, 2'd0, 1'b0, 3'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'd0, 4'b0100, 32'hFFFF_FFFF));
    vecs.push_back(mk(2'd0, 2'd0, 1'b1, 3'd7, 32'd1, 32'h55, 32'h8000_0000, 32'd0, 32'd0, 32'h8000_0000, 4'b1000, 32'h55));
    vecs.push_back(mk(2'd0, 2'd0, 1'b0, 3'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 4'b0101, 32'd1));
    vecs.push_back(mk(2'd0, 2'd0, 1'b0, 3'd1, 32'd0, 32'd1, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 4'b1000, 32'd1));
    vecs.push_back(mk(2'd0, 2'd0, 1'b0, 3'd1, 32'h8000_0000, 32'd1, 32'd0, 32'd0, 32'd0, 32'h7FFF_FFFF, 4'b0011, 32'd1));
    vecs.push_back(mk(2'd3, 2'd3, 1'b0, 3'd0, 32'd3, 32'd4, 32'd0, 32'd100, 32'd200, 32'd7, 4'b0000, 32'd4));
`ifdef ALU_SHIFT_EN
    vecs.push_back(mk(2'd0, 2'd0, 1'b0, 3'd5, 32'd3, 32'h24, 32'd0, 32'd0, 32'd0, 32'h30, 4'b0000, 32'h24));
    vecs.push_back(mk(2'd0, 2'd0, 1'b0, 3'd6, 32'h8000_0000, 32'hFF, 32'd0, 32'd0, 32'd0, 32'd1, 4'b0000, 32'hFF));
`else
    vecs.push_back(mk(2'd0, 2'd0, 1'b0, 3'd5, 32'd3, 32'h24, 32'd0, 32'd0, 32'd0, 32'd0, 4'b0100, 32'h24));
    vecs.push_back(mk(2'd0, 2'd0, 1'b0, 3'd6, 32'h8000_0000, 32'hFF, 32'd0, 32'd0, 32'd0, 32'd0, 4'b0100, 32'hFF));
`endif
    foreach (vecs[i]) begin
      @(posedge clock); #1;
      drive_exec(vecs[i], 3'd0);
      @(negedge clock);
      check_exec($sformatf("vec%0d", i), vecs[i].exp_y, vecs[i].exp_f, vecs[i].exp_r2f);
    end

    // Randomized execute against the reference model
    for (int k = 0; k < 300; k++) begin
      rv.f1 = 2'($urandom); rv.f2 = 2'($urandom); rv.s2 = 1'($urandom); rv.ctrl = 3'($urandom);
      rv.r1 = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : $urandom;
      rv.r2 = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
      rv.im = $urandom; rv.fm = $urandom; rv.fwb = $urandom;
      a   = fwd_pick(rv.f1, rv.r1, rv.fwb, rv.fm);
      r2f = fwd_pick(rv.f2, rv.r2, rv.fwb, rv.fm);
      b   = rv.s2 ? rv.im : r2f;
      alu_model(rv.ctrl, a, b, ey, ef);
      @(posedge clock); #1;
      drive_exec(rv, 3'd0);
      @(negedge clock);
      check_exec($sformatf("rand%0d op%0d", k, rv.ctrl), ey, ef, r2f);
    end

    // Randomized fetch/decode/register file against the reference model
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    m_pc = '0;
    for (int k = 0; k < 300; k++) begin
      pe  = 1'($urandom);
      tbr = ($urandom_range(0, 7) == 0);
      tgt = $urandom;
      we  = 1'($urandom);
      wa  = 4'($urandom);
      wd  = $urandom;
      ins = 24'($urandom);
      u_if.pc_en = pe; u_if.take_branch = tbr; u_if.branch_target = tgt;
      u_if.wb_en = we; u_if.wb_addr = wa; u_if.wb_data = wd; u_if.instruction_d = ins;
      @(negedge clock);
      chk($sformatf("rf%0d pc", k), u_if.pc, m_pc);
      chk($sformatf("rf%0d pc_plus1", k), u_if.pc_plus1, m_pc + 32'd1);
      chk($sformatf("rf%0d reg1", k), u_if.reg1_data, rf_model(ins[15:12], we, wa, wd));
      chk($sformatf("rf%0d reg2", k), u_if.reg2_data, rf_model(ins[11:8], we, wa, wd));
      chk($sformatf("rf%0d opcode", k), 32'(u_if.opcode), 32'(ins[23:20]));
      chk($sformatf("rf%0d rd", k), 32'(u_if.rd_addr), 32'(ins[19:16]));
      iv = int'(ins[11:0]);
      if (iv >= 2048) iv = iv - 4096;
      exp_imm = 32'(iv);
      chk($sformatf("rf%0d imm", k), u_if.imm, exp_imm);
      @(posedge clock); #1;
      if (we && wa != 4'd15) m_regs[wa] = wd;
      if (tbr)     m_pc = tgt;
      else if (pe) m_pc = m_pc + 32'd1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
